uart_tx_baudsel: RTL and testbench

UART transmitter with run-time selectable baud rate, the transmit half of the `uartmod` top level that drives `o_Tx_Serial`. It accepts a byte on a single-cycle valid strobe and serialises it LSB-first as start, 8 data, optional parity and 1 stop bit. The baud rate comes from the same 2-bit `baud_select` that the receive path uses. It is a peer of the UART receiver and shares its frame format and bit-period arithmetic.

---
 rtl/uart_tx_baudsel_if.sv | 20 ++
 rtl/uart_tx_baudsel.sv | 155 +++++++++++++++
 tb/tb_uart_tx_baudsel.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_baudsel_if.sv
// Transmit-side handshake for uart_tx_baudsel: byte strobe and baud select in,
// serial line and frame status out.
interface uart_tx_baudsel_if;
    logic [1:0] i_Baud_Select;
    logic       i_Tx_DV;
    logic [7:0] i_Tx_Byte;
    logic       o_Tx_Serial;
    logic       o_Tx_Active;
    logic       o_Tx_Done;

    modport master (
        output i_Baud_Select, i_Tx_DV, i_Tx_Byte,
        input  o_Tx_Serial, o_Tx_Active, o_Tx_Done
    );

    modport slave (
        input  i_Baud_Select, i_Tx_DV, i_Tx_Byte,
        output o_Tx_Serial, o_Tx_Active, o_Tx_Done
    );
endinterface

// File: rtl/uart_tx_baudsel.sv
// UART transmitter: start, 8 data bits LSB-first, optional parity, 1 stop bit.
// Bit period is chosen per frame from a 2-bit baud select latched at acceptance.
module uart_tx_baudsel #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int PARITY      = 0
) (
    input logic          i_Clock,
    input logic          i_Reset,
    uart_tx_baudsel_if.slave tx
);

    localparam int CPB_0 = (CLK_FREQ_HZ + 9600 / 2) / 9600;
    localparam int CPB_1 = (CLK_FREQ_HZ + 19200 / 2) / 19200;
    localparam int CPB_2 = (CLK_FREQ_HZ + 57600 / 2) / 57600;
    localparam int CPB_3 = (CLK_FREQ_HZ + 115200 / 2) / 115200;

    // The 16-bit counter and the CPB-1 compare need every period in 2..65535.
    if (CPB_0 < 2 || CPB_0 > 65535 || CPB_1 < 2 || CPB_1 > 65535 ||
        CPB_2 < 2 || CPB_2 > 65535 || CPB_3 < 2 || CPB_3 > 65535) begin : g_bad_cpb
        $error("uart_tx_baudsel: bit period out of range 2..65535");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_baudsel: PARITY must be 0, 1 or 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t      state_q;
    logic [15:0] clk_cnt_q;
    logic [2:0]  bit_idx_q;
    logic [7:0]  byte_q;
    logic [15:0] cpb_q;
    logic        par_q;
    logic        serial_q;
    logic        active_q;
    logic        done_q;

    logic [15:0] cpb_d;
    logic        par_d;
    logic        bit_end;

    always_comb begin
        cpb_d = 16'(CPB_0);
        case (tx.i_Baud_Select)
            2'b00:   cpb_d = 16'(CPB_0);
            2'b01:   cpb_d = 16'(CPB_1);
            2'b10:   cpb_d = 16'(CPB_2);
            default: cpb_d = 16'(CPB_3);
        endcase
    end

    // Even parity is the XOR of the data bits; odd parity is its complement.
    assign par_d   = (PARITY == 2) ? ~^tx.i_Tx_Byte : ^tx.i_Tx_Byte;
    assign bit_end = (clk_cnt_q == cpb_q - 16'd1);

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            byte_q    <= '0;
            cpb_q     <= 16'(CPB_0);
            par_q     <= 1'b0;
            serial_q  <= 1'b1;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    serial_q  <= 1'b1;
                    active_q  <= 1'b0;
                    clk_cnt_q <= '0;
                    bit_idx_q <= '0;
                    if (tx.i_Tx_DV) begin
                        byte_q   <= tx.i_Tx_Byte;
                        cpb_q    <= cpb_d;
                        par_q    <= par_d;
                        serial_q <= 1'b0;
                        active_q <= 1'b1;
                        state_q  <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        clk_cnt_q <= '0;
                        bit_idx_q <= '0;
                        serial_q  <= byte_q[0];
                        state_q   <= S_DATA;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        clk_cnt_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            if (PARITY != 0) begin
                                serial_q <= par_q;
                                state_q  <= S_PARITY;
                            end else begin
                                serial_q <= 1'b1;
                                state_q  <= S_STOP;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            serial_q  <= byte_q[bit_idx_q + 3'd1];
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 16'd1;
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        clk_cnt_q <= '0;
                        serial_q  <= 1'b1;
                        state_q   <= S_STOP;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 16'd1;
                    end
                end
                S_STOP: begin
                    // Done and the fall of Active land on the same edge; the FSM
                    // is back in IDLE so a strobe during the Done cycle is taken.
                    if (bit_end) begin
                        clk_cnt_q <= '0;
                        serial_q  <= 1'b1;
                        active_q  <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= S_IDLE;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    clk_cnt_q <= '0;
                    serial_q  <= 1'b1;
                    active_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx.o_Tx_Serial = serial_q;
    assign tx.o_Tx_Active = active_q;
    assign tx.o_Tx_Done   = done_q;

endmodule

// File: tb/tb_uart_tx_baudsel.sv
// Bench for uart_tx_baudsel: line traces are captured per cycle and compared to
// a frame-level model and a mid-bit sampling receiver model.
module tb_uart_tx_baudsel;

    localparam int CLK_HZ = 1_152_000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       dv    = 1'b0;
    logic [7:0] tbyte = 8'h00;
    logic [1:0] sel   = 2'b11;
    int         which = 0;

    uart_tx_baudsel_if if0 ();
    uart_tx_baudsel_if if1 ();
    uart_tx_baudsel_if if2 ();

    uart_tx_baudsel #(.CLK_FREQ_HZ(CLK_HZ), .PARITY(0)) dut0 (.i_Clock(clk), .i_Reset(rst), .tx(if0.slave));
    uart_tx_baudsel #(.CLK_FREQ_HZ(CLK_HZ), .PARITY(1)) dut1 (.i_Clock(clk), .i_Reset(rst), .tx(if1.slave));
    uart_tx_baudsel #(.CLK_FREQ_HZ(CLK_HZ), .PARITY(2)) dut2 (.i_Clock(clk), .i_Reset(rst), .tx(if2.slave));

    assign if0.i_Tx_DV = dv & (which == 0);
    assign if1.i_Tx_DV = dv & (which == 1);
    assign if2.i_Tx_DV = dv & (which == 2);
    assign if0.i_Tx_Byte = tbyte;
    assign if1.i_Tx_Byte = tbyte;
    assign if2.i_Tx_Byte = tbyte;
    assign if0.i_Baud_Select = sel;
    assign if1.i_Baud_Select = sel;
    assign if2.i_Baud_Select = sel;

    logic o_ser, o_act, o_done;
    always_comb begin
        o_ser  = if0.o_Tx_Serial;
        o_act  = if0.o_Tx_Active;
        o_done = if0.o_Tx_Done;
        if (which == 1) begin
            o_ser = if1.o_Tx_Serial; o_act = if1.o_Tx_Active; o_done = if1.o_Tx_Done;
        end else if (which == 2) begin
            o_ser = if2.o_Tx_Serial; o_act = if2.o_Tx_Active; o_done = if2.o_Tx_Done;
        end
    end

    logic ln_q[$];
    logic ac_q[$];
    logic dn_q[$];
    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    function automatic int cpb_of(input int s);
        int bauds[4];
        bauds = '{9600, 19200, 57600, 115200};
        return (CLK_HZ + bauds[s] / 2) / bauds[s];
    endfunction

    function automatic int flen(input int par, input int cpb);
        return ((par != 0) ? 11 : 10) * cpb;
    endfunction

    function automatic logic exp_line(input logic [7:0] b, input int par, input int cpb, input int i);
        int bi;
        bi = i / cpb;
        if (bi == 0) return 1'b0;
        if (bi <= 8) return b[bi-1];
        if (par != 0 && bi == 9) return (par == 1) ? ^b : ~^b;
        return 1'b1;
    endfunction

    // Cycles in the frame window (plus the Done cycle) where the line disagrees.
    function automatic int line_miss(input int off, input logic [7:0] b, input int par, input int cpb);
        int n, len;
        n = 0;
        len = flen(par, cpb);
        for (int i = 0; i <= len; i++) begin
            if (off + i >= ln_q.size()) n++;
            else if (ln_q[off+i] !== ((i == len) ? 1'b1 : exp_line(b, par, cpb, i))) n++;
        end
        return n;
    endfunction

    // Receiver model: sample the middle of each data bit.
    function automatic logic [7:0] rx_decode(input int off, input int cpb);
        logic [7:0] d;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (off + (i+1)*cpb + cpb/2 < ln_q.size()) d[i] = ln_q[off + (i+1)*cpb + cpb/2];
            else d[i] = 1'bx;
        end
        return d;
    endfunction

    function automatic int act_len(input int off);
        int n;
        n = 0;
        while (off + n < ac_q.size() && ac_q[off+n] === 1'b1) n++;
        return n;
    endfunction

    function automatic int done_at(input int off);
        for (int i = off; i < dn_q.size(); i++) if (dn_q[i] === 1'b1) return i - off;
        return -1;
    endfunction

    function automatic int done_count(input int from);
        int n;
        n = 0;
        for (int i = from; i < dn_q.size(); i++) if (dn_q[i] === 1'b1) n++;
        return n;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
        ln_q.push_back(o_ser);
        ac_q.push_back(o_act);
        dn_q.push_back(o_done);
    endtask

    task automatic clr();
        ln_q.delete(); ac_q.delete(); dn_q.delete();
    endtask

    task automatic run_frame(input logic [7:0] b, input logic [1:0] s, input int w, input int ncyc);
        which = w;
        clr();
        tbyte = b; sel = s; dv = 1'b1;
        step();
        dv = 1'b0;
        for (int i = 1; i < ncyc; i++) step();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; dv = 1'b0; which = 0;
        clr();
        repeat (3) step();
        checks++;
        if (ln_q[2] !== 1'b1) begin errors++; $display("FAIL reset_serial: got %b expected 1", ln_q[2]); end
        checks++;
        if (ac_q[2] !== 1'b0) begin errors++; $display("FAIL reset_active: got %b expected 0", ac_q[2]); end
        checks++;
        if (dn_q[2] !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", dn_q[2]); end
        checks++;
        if (if1.o_Tx_Serial !== 1'b1 || if2.o_Tx_Serial !== 1'b1) begin
            errors++; $display("FAIL reset_serial_par: got %b%b expected 11", if1.o_Tx_Serial, if2.o_Tx_Serial);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int m;
        run_frame(8'h55, 2'b11, 0, 105);
        m = line_miss(0, 8'h55, 0, 10);
        checks++;
        if (m !== 0) begin errors++; $display("FAIL basic_line: got %0d bad cycles expected 0", m); end
        checks++;
        if (act_len(0) !== 100) begin errors++; $display("FAIL basic_active: got %0d expected 100", act_len(0)); end
        checks++;
        if (done_at(0) !== 100) begin errors++; $display("FAIL basic_done_at: got %0d expected 100", done_at(0)); end
        checks++;
        if (done_count(0) !== 1) begin errors++; $display("FAIL basic_done_cnt: got %0d expected 1", done_count(0)); end
        checks++;
        if (rx_decode(0, 10) !== 8'h55) begin errors++; $display("FAIL basic_rx: got %h expected 55", rx_decode(0, 10)); end
    endtask

    task automatic test_baud_sweep();
        int cpb, m;
        for (int s = 0; s < 4; s++) begin
            cpb = cpb_of(s);
            run_frame(8'hA3, 2'(s), 0, flen(0, cpb) + 4);
            m = line_miss(0, 8'hA3, 0, cpb);
            checks++;
            if (m !== 0) begin errors++; $display("FAIL sweep_line sel%0d: got %0d bad cycles expected 0", s, m); end
            checks++;
            if (done_at(0) !== 10*cpb) begin errors++; $display("FAIL sweep_len sel%0d: got %0d expected %0d", s, done_at(0), 10*cpb); end
            checks++;
            if (rx_decode(0, cpb) !== 8'hA3) begin errors++; $display("FAIL sweep_rx sel%0d: got %h expected a3", s, rx_decode(0, cpb)); end
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        int s, w, cpb, m;
        for (int it = 0; it < 8; it++) begin
            b = 8'($urandom);
            s = $urandom_range(2, 3);
            w = $urandom_range(0, 2);
            cpb = cpb_of(s);
            run_frame(b, 2'(s), w, flen(w, cpb) + 3);
            m = line_miss(0, b, w, cpb);
            checks++;
            if (m !== 0) begin errors++; $display("FAIL rand_line b=%h sel%0d par%0d: got %0d bad cycles expected 0", b, s, w, m); end
            checks++;
            if (done_at(0) !== flen(w, cpb)) begin errors++; $display("FAIL rand_len b=%h: got %0d expected %0d", b, done_at(0), flen(w, cpb)); end
            checks++;
            if (rx_decode(0, cpb) !== b) begin errors++; $display("FAIL rand_rx: got %h expected %h", rx_decode(0, cpb), b); end
        end
        which = 0;
    endtask

    task automatic test_latch();
        int m;
        which = 0;
        clr();
        tbyte = 8'h0F; sel = 2'b10; dv = 1'b1;
        step();
        dv = 1'b0;
        repeat (10) step();
        tbyte = 8'hFF; sel = 2'b11;
        while (ln_q.size() < 100) step();
        dv = 1'b1;
        step();
        dv = 1'b0;
        repeat (110) step();
        m = line_miss(0, 8'h0F, 0, 20);
        checks++;
        if (m !== 0) begin errors++; $display("FAIL latch_line: got %0d bad cycles expected 0", m); end
        checks++;
        if (done_at(0) !== 200) begin errors++; $display("FAIL latch_len: got %0d expected 200", done_at(0)); end
        checks++;
        if (done_count(0) !== 1 || ac_q[205] !== 1'b0 || ln_q[205] !== 1'b1) begin
            errors++; $display("FAIL latch_second_dv: got %0d done active=%b expected 1 done active=0", done_count(0), ac_q[205]);
        end
    endtask

    task automatic test_back_to_back();
        int m, gaps;
        which = 0;
        clr();
        tbyte = 8'h12; sel = 2'b11; dv = 1'b1;
        step();
        dv = 1'b0;
        while (ln_q.size() < 101) step();
        tbyte = 8'h34; dv = 1'b1;
        step();
        dv = 1'b0;
        repeat (110) step();
        m = line_miss(0, 8'h12, 0, 10) + line_miss(101, 8'h34, 0, 10);
        checks++;
        if (m !== 0) begin errors++; $display("FAIL b2b_line: got %0d bad cycles expected 0", m); end
        checks++;
        if (done_count(0) !== 2) begin errors++; $display("FAIL b2b_done_cnt: got %0d expected 2", done_count(0)); end
        checks++;
        if (done_at(101) !== 100) begin errors++; $display("FAIL b2b_second_len: got %0d expected 100", done_at(101)); end
        gaps = 0;
        for (int i = 0; i < 201; i++) if (ac_q[i] !== 1'b1) gaps++;
        checks++;
        if (gaps !== 1) begin errors++; $display("FAIL b2b_gap: got %0d inactive cycles expected 1", gaps); end
        checks++;
        if (rx_decode(101, 10) !== 8'h34) begin errors++; $display("FAIL b2b_rx: got %h expected 34", rx_decode(101, 10)); end
    endtask

    task automatic test_parity();
        run_frame(8'h07, 2'b11, 1, 115);
        checks++;
        if (ln_q[95] !== 1'b1) begin errors++; $display("FAIL parity_even_bit: got %b expected 1", ln_q[95]); end
        checks++;
        if (done_at(0) !== 110 || line_miss(0, 8'h07, 1, 10) !== 0) begin
            errors++; $display("FAIL parity_even_frame: got done at %0d expected 110", done_at(0));
        end
        run_frame(8'h07, 2'b11, 2, 115);
        checks++;
        if (ln_q[95] !== 1'b0) begin errors++; $display("FAIL parity_odd_bit: got %b expected 0", ln_q[95]); end
        checks++;
        if (done_at(0) !== 110 || line_miss(0, 8'h07, 2, 10) !== 0) begin
            errors++; $display("FAIL parity_odd_frame: got done at %0d expected 110", done_at(0));
        end
        which = 0;
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        int m, bad;
        b = 8'($urandom);
        run_frame(b, 2'b11, 0, 45);
        checks++;
        if (ac_q[44] !== 1'b1) begin errors++; $display("FAIL rmid_pre_active: got %b expected 1", ac_q[44]); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (ln_q[45] !== 1'b1 || ac_q[45] !== 1'b0 || dn_q[45] !== 1'b0) begin
            errors++; $display("FAIL rmid_after: got line=%b act=%b done=%b expected 1 0 0", ln_q[45], ac_q[45], dn_q[45]);
        end
        repeat (80) step();
        bad = done_count(45);
        for (int i = 45; i < ln_q.size(); i++) if (ln_q[i] !== 1'b1 || ac_q[i] !== 1'b0) bad++;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL rmid_abandon: got %0d bad cycles expected 0", bad); end
        // Reset and strobe on the same edge: the byte is dropped.
        clr();
        rst = 1'b1; dv = 1'b1; tbyte = 8'hAA;
        step();
        rst = 1'b0; dv = 1'b0;
        repeat (5) step();
        bad = 0;
        for (int i = 0; i < ac_q.size(); i++) if (ac_q[i] !== 1'b0 || ln_q[i] !== 1'b1) bad++;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL rst_with_dv: got %0d active cycles expected 0", bad); end
        run_frame(8'hC6, 2'b11, 0, 104);
        m = line_miss(0, 8'hC6, 0, 10);
        checks++;
        if (m !== 0 || done_at(0) !== 100) begin
            errors++; $display("FAIL rmid_clean_frame: got %0d bad cycles done at %0d expected 0 and 100", m, done_at(0));
        end
        checks++;
        if (rx_decode(0, 10) !== 8'hC6) begin errors++; $display("FAIL rmid_rx: got %h expected c6", rx_decode(0, 10)); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_baud_sweep();
        test_random();
        test_latch();
        test_back_to_back();
        test_parity();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
